// File: rtl/unified_mem_responder_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
package riscv_mem_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned ERR_BITS   = 3;

  localparam int unsigned ERR_RANGE = 0;
  localparam int unsigned ERR_ALIGN = 1;
  localparam int unsigned ERR_OVF   = 2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

endpackage

// File: rtl/unified_mem_responder_if.sv
// Core fetch/data ports and the image loader stream, grouped as one bundle.
interface unified_mem_responder_if
  import riscv_mem_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH = 32
);

  logic                     inst_ce_i;
  logic [ADDR_WIDTH-1:0]    inst_addr_i;
  logic [WORD_BITWIDTH-1:0] inst_o;

  logic                     data_ce_i;
  logic                     data_we_i;
  logic [ADDR_WIDTH-1:0]    data_addr_i;
  logic [WORD_BITWIDTH-1:0] data_i;
  logic [WORD_BITWIDTH-1:0] data_o;

  logic                     ld_valid_i;
  logic                     ld_ready_o;
  logic [WORD_BITWIDTH-1:0] ld_data_i;
  logic                     ld_last_i;

  modport slave (
    input  inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_addr_i, data_i,
    input  ld_valid_i, ld_data_i, ld_last_i,
    output inst_o, data_o, ld_ready_o
  );

  modport master (
    output inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_addr_i, data_i,
    output ld_valid_i, ld_data_i, ld_last_i,
    input  inst_o, data_o, ld_ready_o
  );

endinterface

// File: rtl/unified_mem_responder_loader.sv
// Boot sequencer: streams the program image into memory, then releases the core.
module mem_loader
  import riscv_mem_pkg::*;
#(
  parameter  int unsigned WORD_BITWIDTH = 32,
  parameter  int unsigned DEPTH_WORDS   = 1024,
  localparam int unsigned ADDR_BITS     = $clog2(DEPTH_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid_i,
  input  logic                     ld_last_i,
  input  logic [WORD_BITWIDTH-1:0] ld_data_i,
  output logic                     ld_ready_o,
  output logic                     core_rst_o,
  output logic                     loaded_o,
  output logic                     ovf_c,
  output logic                     wr_en_c,
  output logic [ADDR_BITS-1:0]     wr_idx_c,
  output logic [WORD_BITWIDTH-1:0] wr_data_c
);

  state_e               state, state_nxt;
  logic [ADDR_BITS-1:0] ptr, ptr_nxt;

  // State, pointer and the state-decoded handshake/status flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      ptr        <= '0;
      ld_ready_o <= 1'b1;
      core_rst_o <= 1'b1;
      loaded_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      ld_ready_o <= (state_nxt == LOAD);
      core_rst_o <= (state_nxt != RUN);
      loaded_o   <= (state_nxt == RUN);
    end
  end

  // Next state and the loader write port; a full array without last ends the load.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ovf_c     = 1'b0;
    wr_en_c   = 1'b0;
    wr_idx_c  = ptr;
    wr_data_c = ld_data_i;
    unique case (state)
      LOAD: begin
        if (ld_valid_i) begin
          wr_en_c = 1'b1;
          ptr_nxt = ptr + ADDR_BITS'(1);
          if (ld_last_i) begin
            state_nxt = RELEASE;
          end else if (ptr == ADDR_BITS'(DEPTH_WORDS - 1)) begin
            state_nxt = RELEASE;
            ovf_c     = 1'b1;
          end
        end
      end
      RELEASE: state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = LOAD;
    endcase
  end

endmodule

// File: rtl/unified_mem_responder.sv
// Unified word array serving zero-wait fetches, loads and stores after image load.
module unified_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter  int unsigned WORD_BITWIDTH = 32,
  parameter  int unsigned DEPTH_WORDS   = 1024,
  localparam int unsigned ADDR_BITS     = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_responder_if.slave bus,
  output logic                 core_rst_o,
  output logic                 loaded_o,
  output logic [ERR_BITS-1:0]  err_o
);

  logic [WORD_BITWIDTH-1:0] mem [DEPTH_WORDS];

  logic                     ld_we;
  logic [ADDR_BITS-1:0]     ld_idx;
  logic [WORD_BITWIDTH-1:0] ld_wdata;
  logic                     ld_ovf;

  logic [ADDR_BITS-1:0]     inst_idx, data_idx;
  logic                     inst_oor, inst_mis, data_oor, data_mis;
  logic                     core_we;
  logic [ERR_BITS-1:0]      err_nxt;

  mem_loader #(
    .WORD_BITWIDTH (WORD_BITWIDTH),
    .DEPTH_WORDS   (DEPTH_WORDS)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .ld_valid_i (bus.ld_valid_i),
    .ld_last_i  (bus.ld_last_i),
    .ld_data_i  (bus.ld_data_i),
    .ld_ready_o (bus.ld_ready_o),
    .core_rst_o (core_rst_o),
    .loaded_o   (loaded_o),
    .ovf_c      (ld_ovf),
    .wr_en_c    (ld_we),
    .wr_idx_c   (ld_idx),
    .wr_data_c  (ld_wdata)
  );

  // Address decode for both core ports.
  always_comb begin
    inst_idx = bus.inst_addr_i[ADDR_BITS+1:2];
    data_idx = bus.data_addr_i[ADDR_BITS+1:2];
    inst_oor = |bus.inst_addr_i[ADDR_WIDTH-1:ADDR_BITS+2];
    data_oor = |bus.data_addr_i[ADDR_WIDTH-1:ADDR_BITS+2];
    inst_mis = |bus.inst_addr_i[1:0];
    data_mis = |bus.data_addr_i[1:0];
    core_we  = loaded_o && bus.data_ce_i && bus.data_we_i && !data_oor && !data_mis;
  end

  // Combinational read muxes; misaligned reads truncate to the word.
  always_comb begin
    bus.inst_o = '0;
    bus.data_o = '0;
    if (loaded_o && bus.inst_ce_i && !inst_oor) begin
      bus.inst_o = mem[inst_idx];
    end
    if (loaded_o && bus.data_ce_i && !bus.data_we_i && !data_oor) begin
      bus.data_o = mem[data_idx];
    end
  end

  // Single write port: loader owns it in LOAD, the core in RUN. Contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_idx] <= ld_wdata;
    end else if (core_we) begin
      mem[data_idx] <= bus.data_i;
    end
  end

  // Sticky error accumulation.
  always_comb begin
    err_nxt = err_o;
    if (loaded_o) begin
      if (bus.inst_ce_i && inst_oor) err_nxt[ERR_RANGE] = 1'b1;
      if (bus.inst_ce_i && inst_mis) err_nxt[ERR_ALIGN] = 1'b1;
      if (bus.data_ce_i && data_oor) err_nxt[ERR_RANGE] = 1'b1;
      if (bus.data_ce_i && data_mis) err_nxt[ERR_ALIGN] = 1'b1;
    end
    if (ld_ovf) err_nxt[ERR_OVF] = 1'b1;
  end

  // Error register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= '0;
    end else begin
      err_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_unified_mem_responder;
  import riscv_mem_pkg::*;

  localparam int K_INST  = 0;
  localparam int K_DATA  = 1;
  localparam int K_READY = 2;
  localparam int K_CRST  = 3;
  localparam int K_LOAD  = 4;
  localparam int K_ERR   = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_rst, loaded;
  logic [2:0] err;

  always #5 clk = ~clk;

  unified_mem_responder_if bus ();

  unified_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .core_rst_o (core_rst),
    .loaded_o   (loaded),
    .err_o      (err)
  );

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          q_cyc [$];
  int          q_kind [$];
  logic [31:0] q_val [$];
  string       q_nm [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_sig(input int kind, input logic [31:0] val, input string nm);
    q_cyc.push_back(cyc);
    q_kind.push_back(kind);
    q_val.push_back(val);
    q_nm.push_back(nm);
  endtask

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      K_INST:  return bus.inst_o;
      K_DATA:  return bus.data_o;
      K_READY: return {31'd0, bus.ld_ready_o};
      K_CRST:  return {31'd0, core_rst};
      K_LOAD:  return {31'd0, loaded};
      default: return {29'd0, err};
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle and compares with the DUT.
  always @(negedge clk) begin : monitor
    int          c, k;
    logic [31:0] v, act;
    string       nm;
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      c  = q_cyc.pop_front();
      k  = q_kind.pop_front();
      v  = q_val.pop_front();
      nm = q_nm.pop_front();
      total++;
      if (c != cyc) begin
        bad++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", nm, c, cyc);
      end else begin
        act = sample(k);
        if (act !== v) begin
          bad++;
          $display("FAIL %s: cycle %0d got %h expected %h", nm, cyc, act, v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      step();
      bus.ld_valid_i = 1'b1;
      bus.ld_data_i  = base + 32'(i);
      bus.ld_last_i  = (i == n - 1);
      expect_sig(K_READY, 32'd1, "load_ready");
      expect_sig(K_CRST,  32'd1, "load_core_rst");
    end
    step();
    bus.ld_data_i = NOP;
    bus.ld_last_i = 1'b0;
    expect_sig(K_READY, 32'd0, "release_ready");
    expect_sig(K_CRST,  32'd1, "release_core_rst");
    expect_sig(K_LOAD,  32'd0, "release_loaded");
    step();
    bus.ld_valid_i = 1'b0;
    expect_sig(K_CRST,  32'd0, "run_core_rst");
    expect_sig(K_LOAD,  32'd1, "run_loaded");
    expect_sig(K_READY, 32'd0, "run_ready");
  endtask

  task automatic core(input logic ice, input logic [31:0] ia,
                      input logic dce, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dd);
    bus.inst_ce_i   = ice;
    bus.inst_addr_i = ia;
    bus.data_ce_i   = dce;
    bus.data_we_i   = dwe;
    bus.data_addr_i = da;
    bus.data_i      = dd;
  endtask

  initial begin
    rst            = 1'b0;
    bus.ld_valid_i = 1'b0;
    bus.ld_data_i  = '0;
    bus.ld_last_i  = 1'b0;
    core(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset values, with both core ports enabled.
    step();
    core(1'b1, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    expect_sig(K_READY, 32'd1, "rst_ready");
    expect_sig(K_CRST,  32'd1, "rst_core_rst");
    expect_sig(K_LOAD,  32'd0, "rst_loaded");
    expect_sig(K_ERR,   32'd0, "rst_err");
    expect_sig(K_INST,  32'd0, "rst_inst");
    expect_sig(K_DATA,  32'd0, "rst_data");
    step();
    rst = 1'b1;
    core(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Two junk beats, then a reset pulse mid-load.
    for (int i = 0; i < 2; i++) begin
      step();
      bus.ld_valid_i = 1'b1;
      bus.ld_data_i  = 32'hBAD0_0000 + 32'(i);
      expect_sig(K_READY, 32'd1, "junk_ready");
    end
    step();
    rst            = 1'b0;
    bus.ld_valid_i = 1'b0;
    expect_sig(K_READY, 32'd1, "midrst_ready");
    expect_sig(K_CRST,  32'd1, "midrst_core_rst");
    expect_sig(K_LOAD,  32'd0, "midrst_loaded");
    step();
    rst = 1'b1;

    // Full 5-word reload; word 0 must overwrite the junk.
    load_image(5, 32'h1111_0000);
    core(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_sig(K_INST, 32'h1111_0000, "reload_word0");
    step();
    core(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_sig(K_INST, 32'h1111_0004, "reload_word4");

    // Reset again and load 4 words.
    step();
    rst = 1'b0;
    core(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    rst = 1'b1;
    load_image(4, 32'h2222_0000);
    core(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_sig(K_INST, 32'h2222_0002, "fetch_0x8");
    step();
    core(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 32'd0);
    expect_sig(K_INST, 32'h1111_0004, "retained_word4");
    expect_sig(K_DATA, 32'h2222_0000, "load_0x0");

    // Store with same-cycle fetch of the same word, then read back.
    step();
    core(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    expect_sig(K_INST, 32'h1111_0004, "fetch_during_store");
    expect_sig(K_DATA, 32'd0,         "data_during_store");
    step();
    core(1'b1, 32'h10, 1'b1, 1'b0, 32'h10, 32'd0);
    expect_sig(K_DATA, 32'hDEAD_BEEF, "load_after_store");
    expect_sig(K_INST, 32'hDEAD_BEEF, "fetch_after_store");
    expect_sig(K_ERR,  32'd0,         "err_clean");

    // Out-of-range load.
    step();
    core(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_1000, 32'd0);
    expect_sig(K_DATA, 32'd0, "oor_load");
    step();
    core(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'd0);
    expect_sig(K_ERR, 32'd1, "oor_err");

    // Misaligned store is dropped.
    step();
    core(1'b0, 32'h0, 1'b1, 1'b1, 32'h6, 32'h5555_5555);
    expect_sig(K_ERR, 32'd1, "oor_err_sticky");
    step();
    core(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'd0);
    expect_sig(K_DATA, 32'h2222_0001, "mis_store_dropped");
    expect_sig(K_ERR,  32'd3,         "mis_err");

    // Out-of-range store aliasing word 4 is dropped.
    step();
    core(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1010, 32'h6666_6666);
    step();
    core(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'd0);
    expect_sig(K_DATA, 32'hDEAD_BEEF, "oor_store_dropped");

    // Misaligned fetch truncates to the word.
    step();
    core(1'b1, 32'h9, 1'b0, 1'b0, 32'h0, 32'd0);
    expect_sig(K_INST, 32'h2222_0002, "mis_fetch");
    expect_sig(K_LOAD, 32'd1,         "still_loaded");
    expect_sig(K_ERR,  32'd3,         "err_sticky");

    // Overflow: DEPTH_WORDS + 1 beats without last.
    step();
    rst = 1'b0;
    core(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_sig(K_ERR, 32'd0, "err_cleared_by_rst");
    step();
    rst = 1'b1;
    for (int i = 0; i < 1025; i++) begin
      step();
      bus.ld_valid_i = 1'b1;
      bus.ld_data_i  = 32'hA000_0000 + 32'(i);
      bus.ld_last_i  = 1'b0;
      if (i < 1024) begin
        expect_sig(K_READY, 32'd1, "ovf_ready");
      end else begin
        expect_sig(K_READY, 32'd0, "ovf_extra_refused");
        expect_sig(K_CRST,  32'd1, "ovf_release");
        expect_sig(K_ERR,   32'd4, "ovf_err");
      end
    end
    step();
    bus.ld_valid_i = 1'b0;
    core(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_sig(K_CRST,  32'd0,         "ovf_core_released");
    expect_sig(K_LOAD,  32'd1,         "ovf_loaded");
    expect_sig(K_ERR,   32'd4,         "ovf_err_sticky");
    expect_sig(K_INST,  32'hA000_0000, "ovf_word0");
    step();
    core(1'b1, 32'hFFC, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_sig(K_INST, 32'hA000_03FF, "ovf_last_word");

    step();
    step();
    if (q_cyc.size() > 0) begin
      total += q_cyc.size();
      bad   += q_cyc.size();
      $display("FAIL unchecked: %0d expectations never reached", q_cyc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
